alu_seq_ctrl: RTL and testbench
===============================

// Module: alu_seq_ctrl
// PURPOSE
//  Sequential initiator for the 16-bit combinational alu (A,B,F,Cin -> Result,Status).
//  - Takes operation requests over a valid/ready channel and drives the alu operand/opcode inputs.
//  - Captures Result/Status and returns them over a valid/ready response channel.
//  - Wide (2*DW) requests run as two chained alu passes: low half first, then the high half
//    with Cin = CF of the low half.
//  - Sits between the instruction/issue logic and the alu; the alu itself is not instantiated here.
// PARAMETERS
//  DW  16  alu datapath width; request operands are 2*DW wide
//  SW  6   status width, bit order {CF,ZF,NF,VF,PF,AF} (CF=bit5 ... AF=bit0)
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous, active-high reset
//  req_valid    in   1      request present
//  req_ready    out  1      controller can accept (high only in IDLE)
//  req_a        in   2*DW   operand A (narrow ops use [DW-1:0])
//  req_b        in   2*DW   operand B
//  req_f        in   5      alu opcode, passed through unmodified
//  req_cin      in   1      carry in for the first (low) pass
//  req_wide     in   1      1 = 2*DW operation, 0 = DW operation
//  alu_a        out  DW     to alu A
//  alu_b        out  DW     to alu B
//  alu_f        out  5      to alu F
//  alu_cin      out  1      to alu Cin
//  alu_result   in   DW     from alu Result
//  alu_status   in   SW     from alu Status
//  rsp_valid    out  1      response present
//  rsp_ready    in   1      consumer accepts response
//  rsp_result   out  2*DW   result; upper DW bits are 0 for narrow ops
//  rsp_status   out  SW     merged status flags
//  busy         out  1      state != IDLE
// BEHAVIOUR
//  - States: IDLE, LO, HI, RESP. Reset returns to IDLE from any state, mid-operation included,
//    and discards any in-flight request.
//  - Reset values: all outputs 0 except req_ready=1.
//  - IDLE: req_ready=1; alu_* driven 0. On req_valid latch a,b,f,cin,wide, then go to LO.
//  - LO: alu_a=a[DW-1:0], alu_b=b[DW-1:0], alu_f=f, alu_cin=cin.
//    At the clock edge capture result_lo and status_lo; go to HI if wide, else to RESP.
//  - HI: alu_a=a[2DW-1:DW], alu_b=b[2DW-1:DW], alu_f=f, alu_cin=status_lo[CF].
//    At the edge capture result_hi and status_hi; go to RESP.
//  - RESP: rsp_valid=1; rsp_result and rsp_status stay stable until rsp_ready.
//    The handshake edge returns to IDLE. The response is held indefinitely under backpressure.
//  - Latency from the acceptance edge to rsp_valid: narrow 2 cycles, wide 3 cycles.
//    Back-to-back throughput is 1 op per 3 cycles (narrow) or 4 cycles (wide).
//  - alu_* are driven from registered state, so there is no comb path from req_* to alu_*.
//  - Status merge:
//    - Narrow: rsp_status = status_lo.
//    - Wide: CF,NF,VF from status_hi; ZF = ZF_lo & ZF_hi; PF,AF from status_lo
//      (low byte / bit-3 semantics).
//  - req_valid while busy is ignored (not accepted); the requester must hold it until req_ready.
//  - Opcode semantics are opaque: the carry chain applies to every opcode when wide=1.
//    Issue logic restricts wide ops to carry-propagating opcodes.
// STRUCTURE
//  - Shared package alu_pkg: state encoding (IDLE/LO/HI/RESP), status bit indices
//    CF..AF, DW/SW defaults.
//  - Single module, no sub-module: a 4-state FSM plus operand/result registers.
//  - The alu is instantiated alongside in the parent or bench.
// TESTING (bench instantiates alu_seq_ctrl + alu; checks against a reference model)
//  1. rst held 3 cycles mid-wide-op (in HI) -> next cycle state IDLE, req_ready=1,
//     rsp_valid=0, alu_* = 0.
//  2. Narrow ADD: a=16'hFFFF, b=16'h0001, cin=0 -> rsp_valid exactly 2 cycles after accept;
//     result=32'h0000_0000, CF=1, ZF=1.
//  3. Wide ADD: a=32'h0000_FFFF, b=32'h0000_0001, cin=0 -> in HI, alu_cin=1;
//     result=32'h0001_0000, ZF=0, CF=0; rsp_valid 3 cycles after accept.
//  4. Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid, rsp_result, rsp_status held
//     constant and req_ready=0 throughout; release -> IDLE next cycle.
//  5. req_valid held high while busy with different operands -> only the first request
//     is executed; the second is accepted only after the response handshake.
//  6. Random regression: 1000 mixed narrow/wide ops with random a,b,f,cin and random
//     rsp_ready -> every response matches the chained reference model; no lost or
//     duplicated responses.

Source files
------------

// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the alu sequencing controller: FSM encoding,
// status flag bit positions and default datapath widths.
package alu_seq_ctrl_pkg;

  localparam int DW_DEF = 16;
  localparam int SW_DEF = 6;
  localparam int FW     = 5;

  // status vector order {CF,ZF,NF,VF,PF,AF}
  localparam int CF = 5;
  localparam int ZF = 4;
  localparam int NF = 3;
  localparam int VF = 2;
  localparam int PF = 1;
  localparam int AF = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/alu_seq_ctrl.sv
// Sequential initiator for a combinational alu: issues one pass (narrow) or two
// carry-chained passes (wide) per request and returns the result on a valid/ready port.
//
// state   | meaning
// IDLE    | ready for a request, alu inputs parked at 0
// LO      | low half on the alu, capture result/status at the edge
// HI      | high half on the alu with Cin = CF of low half (wide only)
// RESP    | response held until the consumer takes it
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int SW = SW_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [2*DW-1:0] i_req_a,
  input  logic [2*DW-1:0] i_req_b,
  input  logic [FW-1:0]   i_req_f,
  input  logic            i_req_cin,
  input  logic            i_req_wide,
  output logic [DW-1:0]   o_alu_a,
  output logic [DW-1:0]   o_alu_b,
  output logic [FW-1:0]   o_alu_f,
  output logic            o_alu_cin,
  input  logic [DW-1:0]   i_alu_result,
  input  logic [SW-1:0]   i_alu_status,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [2*DW-1:0] o_rsp_result,
  output logic [SW-1:0]   o_rsp_status,
  output logic            o_busy
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2*DW-1:0] r_a;
  logic [2*DW-1:0] r_b;
  logic [FW-1:0]   r_f;
  logic            r_cin;
  logic            r_wide;
  logic [DW-1:0]   r_res_lo;
  logic [DW-1:0]   r_res_hi;
  logic [SW-1:0]   r_st_lo;
  logic [SW-1:0]   r_st_hi;
  logic            w_accept;
  logic [SW-1:0]   w_st_merged;

  assign w_accept = (r_state == ST_IDLE) && i_req_valid;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_req_valid) w_state_nxt = ST_LO;
      ST_LO:   w_state_nxt = r_wide ? ST_HI : ST_RESP;
      ST_HI:   w_state_nxt = ST_RESP;
      ST_RESP: if (i_rsp_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_f      <= '0;
      r_cin    <= 1'b0;
      r_wide   <= 1'b0;
      r_res_lo <= '0;
      r_res_hi <= '0;
      r_st_lo  <= '0;
      r_st_hi  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a    <= i_req_a;
        r_b    <= i_req_b;
        r_f    <= i_req_f;
        r_cin  <= i_req_cin;
        r_wide <= i_req_wide;
      end
      if (r_state == ST_LO) begin
        r_res_lo <= i_alu_result;
        r_st_lo  <= i_alu_status;
      end
      if (r_state == ST_HI) begin
        r_res_hi <= i_alu_result;
        r_st_hi  <= i_alu_status;
      end
    end
  end

  // Wide flags: sign/carry/overflow describe the top half, zero spans both,
  // parity and aux-carry keep their low-byte / bit-3 meaning.
  always_comb begin
    w_st_merged     = r_st_hi;
    w_st_merged[ZF] = r_st_lo[ZF] & r_st_hi[ZF];
    w_st_merged[PF] = r_st_lo[PF];
    w_st_merged[AF] = r_st_lo[AF];
  end

  always_comb begin
    o_req_ready  = 1'b0;
    o_busy       = 1'b1;
    o_alu_a      = '0;
    o_alu_b      = '0;
    o_alu_f      = '0;
    o_alu_cin    = 1'b0;
    o_rsp_valid  = 1'b0;
    o_rsp_result = '0;
    o_rsp_status = '0;
    case (r_state)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        o_busy      = 1'b0;
      end
      ST_LO: begin
        o_alu_a   = r_a[DW-1:0];
        o_alu_b   = r_b[DW-1:0];
        o_alu_f   = r_f;
        o_alu_cin = r_cin;
      end
      ST_HI: begin
        o_alu_a   = r_a[2*DW-1:DW];
        o_alu_b   = r_b[2*DW-1:DW];
        o_alu_f   = r_f;
        o_alu_cin = r_st_lo[CF];
      end
      ST_RESP: begin
        o_rsp_valid  = 1'b1;
        o_rsp_result = {(r_wide ? r_res_hi : {DW{1'b0}}), r_res_lo};
        o_rsp_status = r_wide ? w_st_merged : r_st_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed and randomized bench for alu_seq_ctrl with a small behavioural alu
// (0 ADD, 1 SUB with carry-as-not-borrow, 2 AND, other XOR).
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_f;
  logic        req_cin;
  logic        req_wide;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [4:0]  alu_f;
  logic        alu_cin;
  logic [15:0] alu_result;
  logic [5:0]  alu_status;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [5:0]  rsp_status;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.DW(16), .SW(6)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_f(req_f),
    .i_req_cin(req_cin), .i_req_wide(req_wide),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_f(alu_f), .o_alu_cin(alu_cin),
    .i_alu_result(alu_result), .i_alu_status(alu_status),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_result(rsp_result), .o_rsp_status(rsp_status),
    .o_busy(busy)
  );

  // returns {CF,ZF,NF,VF,PF,AF, result[15:0]}
  function automatic logic [21:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [4:0] f, input logic cin);
    logic [16:0] s;
    logic [4:0]  h;
    logic [15:0] bb;
    logic        c, v, ax;
    bb = (f == 5'd1) ? ~b : b;
    if (f <= 5'd1) begin
      s  = {1'b0, a} + {1'b0, bb} + {16'd0, cin};
      h  = {1'b0, a[3:0]} + {1'b0, bb[3:0]} + {4'd0, cin};
      c  = s[16];
      v  = (a[15] == bb[15]) && (s[15] != a[15]);
      ax = h[4];
    end else begin
      s  = {1'b0, (f == 5'd2) ? (a & b) : (a ^ b)};
      c  = 1'b0;
      v  = 1'b0;
      ax = 1'b0;
    end
    return {c, (s[15:0] == 16'd0), s[15], v, ~^s[7:0], ax, s[15:0]};
  endfunction

  // returns {status[5:0], result[31:0]} for the whole chained operation
  function automatic logic [37:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] f, input logic cin,
                                         input logic wide);
    logic [21:0] lo, hi;
    logic [5:0]  st;
    lo = alu_fn(a[15:0], b[15:0], f, cin);
    if (!wide) return {lo[21:16], 16'd0, lo[15:0]};
    hi = alu_fn(a[31:16], b[31:16], f, lo[21]);
    st = hi[21:16];
    st[4] = lo[20] & hi[20];
    st[1] = lo[17];
    st[0] = lo[16];
    return {st, hi[15:0], lo[15:0]};
  endfunction

  assign {alu_status, alu_result} = alu_fn(alu_a, alu_b, alu_f, alu_cin);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] f,
                        input logic cin, input logic wide, input int dly,
                        input logic [31:0] exp_res, input logic [5:0] exp_st);
    int          lat;
    logic        ok;
    logic [21:0] lo;
    lo = alu_fn(a[15:0], b[15:0], f, cin);
    req_a = a; req_b = b; req_f = f; req_cin = cin; req_wide = wide;
    req_valid = 1'b1;
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    chk("lo_alu", {27'd0, alu_f, alu_cin, alu_a, alu_b},
        {27'd0, f, cin, a[15:0], b[15:0]});
    lat = 1;
    if (wide) begin
      tick();
      lat = 2;
      chk("hi_alu", {27'd0, alu_f, alu_cin, alu_a, alu_b},
          {27'd0, f, lo[21], a[31:16], b[31:16]});
    end
    while (!rsp_valid && lat < 8) begin
      tick();
      lat++;
    end
    chk("latency", 64'(lat), wide ? 64'd3 : 64'd2);
    chk("rsp", {26'd0, rsp_status, rsp_result}, {26'd0, exp_st, exp_res});
    chk("busy_resp", {62'd0, req_ready, busy}, 64'b01);
    ok = 1'b1;
    for (int i = 0; i < dly; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_result !== exp_res || rsp_status !== exp_st ||
          req_ready !== 1'b0)
        ok = 1'b0;
    end
    if (dly > 0) chk("hold", 64'(ok), 64'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("idle_after", {61'd0, rsp_valid, busy, req_ready}, 64'b001);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  f;
    logic        cin;
    logic        wide;
    int          dly;
    logic [31:0] res;
    logic [5:0]  st;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [37:0] r;
    logic [31:0] ra, rb;
    logic [4:0]  rf;
    logic        rc, rw;

    // hand-computed vectors
    vecs[0] = '{32'h0000_FFFF, 32'h0000_0001, 5'd0, 1'b0, 1'b0, 0, 32'h0000_0000, 6'h33};
    vecs[1] = '{32'h0000_FFFF, 32'h0000_0001, 5'd0, 1'b0, 1'b1, 5, 32'h0001_0000, 6'h03};
    vecs[2] = '{32'h0000_0005, 32'h0000_0007, 5'd1, 1'b1, 1'b0, 2, 32'h0000_FFFE, 6'h08};
    vecs[3] = '{32'hFF00_00FF, 32'h0F0F_00FF, 5'd3, 1'b0, 1'b1, 1, 32'hF00F_0000, 6'h0A};

    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_f = '0;
    req_cin = 1'b0; req_wide = 1'b0; rsp_ready = 1'b0;
    repeat (3) tick();
    chk("reset_state", {26'd0, req_ready, rsp_valid, busy, alu_cin, alu_a, alu_b, alu_f},
        {26'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 5'd0});
    chk("reset_rsp", {26'd0, rsp_status, rsp_result}, 64'd0);
    rst = 1'b0;

    // reset in the middle of a wide op (state HI)
    req_a = 32'h0000_FFFF; req_b = 32'h0000_0001; req_f = 5'd0; req_wide = 1'b1;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("mid_hi_cin", 64'(alu_cin), 64'd1);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_mid_op", {26'd0, req_ready, rsp_valid, busy, alu_cin, alu_a, alu_b, alu_f},
        {26'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 5'd0});
    repeat (3) tick();
    chk("rst_discard", {62'd0, rsp_valid, busy}, 64'd0);

    for (int i = 0; i < 4; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].cin, vecs[i].wide, vecs[i].dly,
             vecs[i].res, vecs[i].st);

    // req_valid held while busy with changed operands
    req_a = 32'h0000_0001; req_b = 32'h0000_0002; req_f = 5'd0; req_cin = 1'b0;
    req_wide = 1'b0; req_valid = 1'b1;
    tick();
    req_a = 32'h0000_00F0; req_b = 32'h0000_000F; req_f = 5'd3;
    chk("busy_lo_a", 64'(alu_a), 64'h1);
    tick();
    tick();
    chk("busy_first", {26'd0, rsp_status, rsp_result}, {26'd0, 6'h02, 32'h0000_0003});
    chk("busy_not_ready", 64'(req_ready), 64'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("second_wait", {62'd0, req_ready, rsp_valid}, 64'b10);
    tick();
    req_valid = 1'b0;
    chk("second_lo", {43'd0, alu_f, alu_a}, {43'd0, 5'd3, 16'h00F0});
    tick();
    chk("second_rsp", {26'd0, rsp_status, rsp_result}, {26'd0, 6'h02, 32'h0000_00FF});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("second_done", {62'd0, rsp_valid, busy}, 64'd0);

    // randomized regression against the chained reference
    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      rb = $urandom;
      rf = 5'($urandom_range(0, 3));
      rc = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      r  = ref_op(ra, rb, rf, rc, rw);
      run_op(ra, rb, rf, rc, rw, int'($urandom_range(0, 3)), r[31:0], r[37:32]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
